// File: rtl/student_iic_master.sv
// student_iic_master: byte-level I2C master driven by START/WRITE/READ/STOP commands.
// Each command runs to completion and reports back with a one-cycle rsp_valid_o pulse.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cmd_valid_i, cmd_ready_o   command handshake (ready only in IDLE)
//   cmd_i, wdata_i, ack_i      command code, WRITE byte, READ ack choice
//   rsp_valid_o, rdata_o       completion pulse, last byte read
//   nack_o, busy_o             WRITE ack result, FSM not idle
//   sda_i, scl_i               raw pad levels
//   sda_oe, scl_oe             1 = pull line low (registered)
// Optional macro STUDENT_IIC_CLK_STRETCH_EN enables slave clock stretching.
module student_iic_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] wdata_i,
    input  logic       ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rdata_o,
    output logic       nack_o,
    output logic       busy_o,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_oe,
    output logic       scl_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
    } state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;
    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        rsp_q, rsp_d;
    logic        sda_oe_q, sda_oe_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_s1_q, sda_s2_q;
    logic        scl_s1_q, scl_s2_q;
    logic        tick;
    logic        hold;

    assign tick = (cnt_q == TICK_LAST);

`ifdef STUDENT_IIC_CLK_STRETCH_EN
    // Counter stays at 0 while a slave holds SCL low after release,
    // so a full tick follows once SCL is seen high.
    assign hold = (phase_q == 2'd1) && !scl_s2_q &&
                  (state_q == S_BIT || state_q == S_ACK || state_q == S_STOP);
`else
    logic unused_scl;
    assign unused_scl = scl_s2_q;
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        ack_d    = ack_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        rsp_d    = 1'b0;
        sda_oe_d = sda_oe_q;
        scl_oe_d = scl_oe_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                phase_d = '0;
                if (cmd_valid_i) begin
                    cmd_d   = cmd_i;
                    wdata_d = wdata_i;
                    ack_d   = ack_i;
                    bit_d   = 3'd7;
                    case (cmd_i)
                        CMD_START: state_d = S_START;
                        CMD_STOP:  state_d = S_STOP;
                        default:   state_d = S_BIT;
                    endcase
                end
            end
            S_DONE: begin
                rsp_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                if (hold)      cnt_d = cnt_q;
                else if (tick) cnt_d = '0;
                else           cnt_d = cnt_q + 16'd1;
                if (tick && !hold) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2 && state_q == S_BIT)
                        shift_d = {shift_q[6:0], sda_s2_q};
                    if (phase_q == 2'd2 && state_q == S_ACK && cmd_q == CMD_WRITE)
                        nack_d = sda_s2_q;
                    if (phase_q == 2'd3) begin
                        if (state_q == S_BIT) begin
                            if (bit_q == 3'd0) state_d = S_ACK;
                            else               bit_d = bit_q - 3'd1;
                        end else begin
                            state_d = S_DONE;
                            if (state_q == S_ACK && cmd_q == CMD_READ)
                                rdata_d = shift_q;
                        end
                    end
                end
            end
        endcase

        // Line drive per phase; held outside the listed phases.
        case (state_q)
            S_START: begin
                case (phase_q)
                    2'd0: begin sda_oe_d = 1'b0; scl_oe_d = 1'b0; end
                    2'd1: sda_oe_d = 1'b1;
                    2'd3: scl_oe_d = 1'b1;
                    default: ;
                endcase
            end
            S_BIT, S_ACK: begin
                case (phase_q)
                    2'd0: begin
                        scl_oe_d = 1'b1;
                        if (state_q == S_BIT)
                            sda_oe_d = (cmd_q == CMD_WRITE) && !wdata_q[bit_q];
                        else
                            sda_oe_d = (cmd_q == CMD_READ) && ack_q;
                    end
                    2'd1: scl_oe_d = 1'b0;
                    2'd3: scl_oe_d = 1'b1;
                    default: ;
                endcase
            end
            S_STOP: begin
                case (phase_q)
                    2'd0: begin sda_oe_d = 1'b1; scl_oe_d = 1'b1; end
                    2'd1: scl_oe_d = 1'b0;
                    2'd2: sda_oe_d = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            cmd_q    <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            shift_q  <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            rsp_q    <= 1'b0;
            sda_oe_q <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            cmd_q    <= cmd_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            rsp_q    <= rsp_d;
            sda_oe_q <= sda_oe_d;
            scl_oe_q <= scl_oe_d;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = rsp_q;
    assign rdata_o     = rdata_q;
    assign nack_o      = nack_q;
    assign sda_oe      = sda_oe_q;
    assign scl_oe      = scl_oe_q;

endmodule
